reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  8 x 16-bit register file; sink of the writeback port (signal_wr_reg: ena, adr[2:0], data[15:0]).
//  Provides two read ports for decode plus a pending-write scoreboard that raises stall_o.
//  stall_o asserts when decode reads a register whose result has not yet been written back.
//  Sits between the writeback select stage and the decode/issue stage of the pipeline.
// PARAMETERS
//  DATA_W    16  register width; must equal signal_wr_reg.data width
//  ADR_W     3   register address width; NREG = 2**ADR_W (localparam, 8)
//  ZERO_REG  1   1: r0 reads 0, ignores writes, never busy; 0: r0 is an ordinary register
// PORTS
//  clk_i        in   1        single clock, all state updates on rising edge
//  rst_i        in   1        synchronous reset, active-high
//  wr_reg_i     in   struct   signal_wr_reg {ena, adr[ADR_W-1:0], data[DATA_W-1:0]} from writeback
//  rd_a_ena_i   in   1        read port A in use (qualifies stall)
//  rd_a_adr_i   in   ADR_W    read port A address
//  rd_a_data_o  out  DATA_W   read port A data (combinational)
//  rd_b_ena_i   in   1        read port B in use
//  rd_b_adr_i   in   ADR_W    read port B address
//  rd_b_data_o  out  DATA_W   read port B data (combinational)
//  issue_ena_i  in   1        instruction issued that will write issue_adr_i later
//  issue_adr_i  in   ADR_W    destination of issued instruction
//  busy_o       out  NREG     scoreboard vector, bit n = write to rn pending
//  stall_o      out  1        decode must hold this cycle
//  err_o        out  1        sticky: writeback to a register that was not busy
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): all registers <= 0, busy_o <= 0, err_o <= 0; wr_reg_i/issue ignored that cycle.
//    Outputs after reset: rd data 0, stall_o 0. Reset mid-operation discards all pending state.
//  - Write: wr_reg_i.ena=1 at edge -> regs[adr] <= data; 1-cycle write latency (visible from next cycle).
//  - Read: rd_x_data_o = regs[rd_x_adr_i] combinationally; with ZERO_REG=1 adr 0 returns 0.
//  - Scoreboard at edge: issue_ena_i sets busy[issue_adr_i]; wr_reg_i.ena clears busy[wr_reg_i.adr].
//    Same address set+clear in one cycle -> set wins (new pending write supersedes).
//    Issue to an already-busy register: stays busy (single bit, no count).
//    ZERO_REG=1: busy[0] held 0; writes/issues to r0 have no effect.
//  - err_o: set at edge when wr_reg_i.ena=1 and busy[adr]=0 (adr!=0 if ZERO_REG); write still performed.
//    Cleared only by reset.
//  - stall_o = (rd_a_ena_i & hit_a) | (rd_b_ena_i & hit_b); hit_x = busy[rd_x_adr_i] & ~bypass_x.
//    Purely combinational from current state; issue_ena_i this cycle does not affect stall_o.
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined: bypass_x = wr_reg_i.ena & (wr_reg_i.adr == rd_x_adr_i);
//    on a match rd_x_data_o = wr_reg_i.data the same cycle and no stall for that port.
//  Not defined: bypass_x = 0; reader stalls during the writeback cycle, data visible next cycle
//    (one extra stall cycle per RAW hazard).
// STRUCTURE
//  Package (my_struct): signal_wr_reg typedef (existing), REG_ADR_W=3, REG_DATA_W=16, NUM_REGS=8.
//  Sub-module reg_scoreboard: busy vector set/clear, err_o, stall/hit logic; reg_file holds storage + read mux.
// TESTING
//  1 Reset: write 16'hFFFF to all regs, assert rst_i 1 cycle -> every read returns 0, busy_o=0, err_o=0.
//  2 Issue r3, next cycle read A r3 -> stall_o=1; wb {1,3,16'h1234} -> busy_o[3]=0 after edge;
//    with bypass A=16'h1234, stall_o=0 in wb cycle; without, stall_o=1 in wb cycle, A=16'h1234 next cycle.
//  3 Same-cycle issue r5 and wb r5 (r5 previously busy) -> busy_o[5] stays 1, regs[5] updated.
//  4 wb {1,2,16'h00AA} with busy_o[2]=0 -> err_o=1 and holds; regs[2]=16'h00AA; cleared only by rst_i.
//  5 ZERO_REG=1: issue r0 and wb {1,0,16'hBEEF} -> busy_o[0]=0, read r0 = 0, err_o unchanged, no stall.
//  6 Ports A=r1 (busy), B=r4 (idle), rd_a_ena_i=0 -> stall_o=0; set rd_a_ena_i=1 -> stall_o=1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and the writeback port struct for the register file.
package reg_file_pkg;

  localparam int REG_ADR_W  = 3;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 2 ** REG_ADR_W;

  typedef struct packed {
    logic                  ena;
    logic [REG_ADR_W-1:0]  adr;
    logic [REG_DATA_W-1:0] data;
  } signal_wr_reg;

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - writeback, decode read and issue signals of the register file.
interface reg_file_if;
  import reg_file_pkg::*;

  signal_wr_reg          wr_reg_i;
  logic                  rd_a_ena_i;
  logic [REG_ADR_W-1:0]  rd_a_adr_i;
  logic [REG_DATA_W-1:0] rd_a_data_o;
  logic                  rd_b_ena_i;
  logic [REG_ADR_W-1:0]  rd_b_adr_i;
  logic [REG_DATA_W-1:0] rd_b_data_o;
  logic                  issue_ena_i;
  logic [REG_ADR_W-1:0]  issue_adr_i;
  logic [NUM_REGS-1:0]   busy_o;
  logic                  stall_o;
  logic                  err_o;

  modport master (
    output wr_reg_i, rd_a_ena_i, rd_a_adr_i, rd_b_ena_i, rd_b_adr_i,
           issue_ena_i, issue_adr_i,
    input  rd_a_data_o, rd_b_data_o, busy_o, stall_o, err_o
  );

  modport slave (
    input  wr_reg_i, rd_a_ena_i, rd_a_adr_i, rd_b_ena_i, rd_b_adr_i,
           issue_ena_i, issue_adr_i,
    output rd_a_data_o, rd_b_data_o, busy_o, stall_o, err_o
  );

endinterface

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - pending-write busy vector, sticky writeback error and decode stall.
module reg_file_scoreboard #(
  parameter int ADR_W    = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_ena_i,
  input  logic [ADR_W-1:0]    wr_adr_i,
  input  logic                issue_ena_i,
  input  logic [ADR_W-1:0]    issue_adr_i,
  input  logic                rd_a_ena_i,
  input  logic [ADR_W-1:0]    rd_a_adr_i,
  input  logic                bypass_a_i,
  input  logic                rd_b_ena_i,
  input  logic [ADR_W-1:0]    rd_b_adr_i,
  input  logic                bypass_b_i,
  output logic [2**ADR_W-1:0] busy_o,
  output logic                stall_o,
  output logic                err_o
);

  logic [2**ADR_W-1:0] busy_q;
  logic [2**ADR_W-1:0] busy_nxt;
  logic                err_q;
  logic                err_set;
  logic                hit_a;
  logic                hit_b;

  // Issue is applied after writeback so a new pending write supersedes the retiring one.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_ena_i)    busy_nxt[wr_adr_i]    = 1'b0;
    if (issue_ena_i) busy_nxt[issue_adr_i] = 1'b1;
    if (ZERO_REG)    busy_nxt[0]           = 1'b0;
  end

  assign err_set = wr_ena_i & ~busy_q[wr_adr_i] & ~(ZERO_REG & (wr_adr_i == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign hit_a   = busy_q[rd_a_adr_i] & ~bypass_a_i;
  assign hit_b   = busy_q[rd_b_adr_i] & ~bypass_b_i;
  assign stall_o = (rd_a_ena_i & hit_a) | (rd_b_ena_i & hit_b);
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8x16 register file with two read ports and a pending-write scoreboard.
// Optional writeback-to-read forwarding: define REG_FILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADR_W    = REG_ADR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  reg_file_if.slave  bus
);

  localparam int NREG = 2 ** ADR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              bypass_a;
  logic              bypass_b;
  logic              wr_en;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

`ifdef REG_FILE_BYPASS_EN
  assign bypass_a = bus.wr_reg_i.ena & (bus.wr_reg_i.adr == bus.rd_a_adr_i);
  assign bypass_b = bus.wr_reg_i.ena & (bus.wr_reg_i.adr == bus.rd_b_adr_i);
`else
  assign bypass_a = 1'b0;
  assign bypass_b = 1'b0;
`endif

  assign wr_en = bus.wr_reg_i.ena & ~(ZERO_REG & (bus.wr_reg_i.adr == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.wr_reg_i.adr] <= bus.wr_reg_i.data;
    end
  end

  // The hardwired zero check comes last so forwarding can never leak a value onto r0.
  always_comb begin
    rd_a = regs[bus.rd_a_adr_i];
    if (bypass_a) rd_a = bus.wr_reg_i.data;
    if (ZERO_REG && (bus.rd_a_adr_i == '0)) rd_a = '0;
    rd_b = regs[bus.rd_b_adr_i];
    if (bypass_b) rd_b = bus.wr_reg_i.data;
    if (ZERO_REG && (bus.rd_b_adr_i == '0)) rd_b = '0;
  end

  assign bus.rd_a_data_o = rd_a;
  assign bus.rd_b_data_o = rd_b;

  reg_file_scoreboard #(
    .ADR_W    (ADR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_ena_i    (bus.wr_reg_i.ena),
    .wr_adr_i    (bus.wr_reg_i.adr),
    .issue_ena_i (bus.issue_ena_i),
    .issue_adr_i (bus.issue_adr_i),
    .rd_a_ena_i  (bus.rd_a_ena_i),
    .rd_a_adr_i  (bus.rd_a_adr_i),
    .bypass_a_i  (bypass_a),
    .rd_b_ena_i  (bus.rd_b_ena_i),
    .rd_b_adr_i  (bus.rd_b_adr_i),
    .bypass_b_i  (bypass_b),
    .busy_o      (bus.busy_o),
    .stall_o     (bus.stall_o),
    .err_o       (bus.err_o)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file (either REG_FILE_BYPASS_EN setting).
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wb(input logic ena, input logic [2:0] adr, input logic [15:0] data);
    bus.wr_reg_i = signal_wr_reg'{ena, adr, data};
  endtask

  task automatic idle();
    wb(1'b0, 3'd0, 16'h0);
    bus.issue_ena_i = 1'b0;
    bus.issue_adr_i = 3'd0;
  endtask

  initial begin
    idle();
    bus.rd_a_ena_i = 1'b0;
    bus.rd_a_adr_i = 3'd0;
    bus.rd_b_ena_i = 1'b0;
    bus.rd_b_adr_i = 3'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 1: fill with FFFF, then reset clears everything
    for (int i = 0; i < 8; i++) begin
      wb(1'b1, 3'(i), 16'hFFFF);
      step();
    end
    idle();
    bus.rd_a_adr_i = 3'd7;
    #1 check("pre_rst_r7", bus.rd_a_data_o, 16'hFFFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_a_adr_i = 3'(i);
      bus.rd_b_adr_i = 3'(7 - i);
      #1;
      check($sformatf("rst_a_r%0d", i), bus.rd_a_data_o, 16'h0);
      check($sformatf("rst_b_r%0d", 7 - i), bus.rd_b_data_o, 16'h0);
    end
    check("rst_busy", 16'(bus.busy_o), 16'h0);
    check("rst_err", 16'(bus.err_o), 16'h0);
    check("rst_stall", 16'(bus.stall_o), 16'h0);

    // 2: RAW hazard on r3
    bus.issue_ena_i = 1'b1;
    bus.issue_adr_i = 3'd3;
    step();
    idle();
    bus.rd_a_ena_i = 1'b1;
    bus.rd_a_adr_i = 3'd3;
    #1 check("raw_busy", 16'(bus.busy_o), 16'h0008);
    check("raw_stall", 16'(bus.stall_o), 16'h1);
    wb(1'b1, 3'd3, 16'h1234);
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("raw_wb_stall", 16'(bus.stall_o), 16'h0);
    check("raw_wb_data", bus.rd_a_data_o, 16'h1234);
`else
    check("raw_wb_stall", 16'(bus.stall_o), 16'h1);
`endif
    step();
    idle();
    #1 check("raw_post_busy", 16'(bus.busy_o), 16'h0);
    check("raw_post_stall", 16'(bus.stall_o), 16'h0);
    check("raw_post_data", bus.rd_a_data_o, 16'h1234);
    check("raw_err", 16'(bus.err_o), 16'h0);
    bus.rd_a_ena_i = 1'b0;

    // 3: same-cycle issue and writeback on busy r5
    bus.issue_ena_i = 1'b1;
    bus.issue_adr_i = 3'd5;
    step();
    wb(1'b1, 3'd5, 16'h5555);
    step();
    idle();
    bus.rd_b_adr_i = 3'd5;
    #1 check("same_busy", 16'(bus.busy_o), 16'h0020);
    check("same_data", bus.rd_b_data_o, 16'h5555);
    check("same_err", 16'(bus.err_o), 16'h0);

    // 5: r0 is hardwired zero
    bus.issue_ena_i = 1'b1;
    bus.issue_adr_i = 3'd0;
    wb(1'b1, 3'd0, 16'hBEEF);
    step();
    idle();
    bus.rd_a_ena_i = 1'b1;
    bus.rd_a_adr_i = 3'd0;
    #1 check("r0_busy", 16'(bus.busy_o), 16'h0020);
    check("r0_data", bus.rd_a_data_o, 16'h0);
    check("r0_err", 16'(bus.err_o), 16'h0);
    check("r0_stall", 16'(bus.stall_o), 16'h0);

    // 6: stall qualified by read enables
    bus.issue_ena_i = 1'b1;
    bus.issue_adr_i = 3'd1;
    step();
    idle();
    bus.rd_a_ena_i = 1'b0;
    bus.rd_a_adr_i = 3'd1;
    bus.rd_b_ena_i = 1'b1;
    bus.rd_b_adr_i = 3'd4;
    #1 check("ena_off_stall", 16'(bus.stall_o), 16'h0);
    bus.rd_a_ena_i = 1'b1;
    #1 check("ena_on_stall", 16'(bus.stall_o), 16'h1);
    bus.rd_a_ena_i = 1'b0;
    bus.rd_b_adr_i = 3'd5;
    #1 check("port_b_stall", 16'(bus.stall_o), 16'h1);
    bus.rd_b_ena_i = 1'b0;

    // re-issue of a busy register is a single bit: one writeback retires it
    bus.issue_ena_i = 1'b1;
    bus.issue_adr_i = 3'd1;
    step();
    idle();
    #1 check("reissue_busy", 16'(bus.busy_o), 16'h0022);
    wb(1'b1, 3'd1, 16'h0101);
    step();
    idle();
    #1 check("reissue_clear", 16'(bus.busy_o), 16'h0020);
    check("reissue_err", 16'(bus.err_o), 16'h0);

    // 4: writeback to idle r2 flags err, is sticky, and only reset clears it
    wb(1'b1, 3'd2, 16'h00AA);
    step();
    idle();
    bus.rd_a_adr_i = 3'd2;
    #1 check("err_set", 16'(bus.err_o), 16'h1);
    check("err_data", bus.rd_a_data_o, 16'h00AA);
    step();
    step();
    check("err_hold", 16'(bus.err_o), 16'h1);
    rst = 1'b1;
    bus.issue_ena_i = 1'b1;
    bus.issue_adr_i = 3'd6;
    step();
    rst = 1'b0;
    idle();
    #1 check("rst2_err", 16'(bus.err_o), 16'h0);
    check("rst2_busy", 16'(bus.busy_o), 16'h0);
    check("rst2_data", bus.rd_a_data_o, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
